inst_mem_fetch: RTL and testbench

- Instruction-memory responder at the far end of the PC stage's fetch address.
- Takes the registered fetch address each cycle and returns the addressed 32-bit instruction, its PC and a valid flag one cycle later, ready for the IF/ID register.
- Honours the same stall and flush signals the PC stage uses.
- Provides a boot-load write port so the bench or host can fill memory before the core runs.

---
 rtl/inst_mem_fetch.sv | 115 +++++++++++
 tb/tb_inst_mem_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_fetch.sv
// Instruction memory responder: boot-load port fills the array, then the
// array serves the PC stage's fetch address with a one-cycle registered read.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

// state  | meaning
// S_LOAD | accepting boot words, fetch outputs parked at NOP/invalid
// S_RUN  | memory read-only, fetch active
module inst_mem_fetch #(
  parameter int unsigned      ADDR_WIDTH = `INST_ADDR_WIDTH,
  parameter int unsigned      DEPTH      = 1024,
  parameter logic [31:0]      NOP        = 32'h0000_0013,
  parameter int unsigned      PRELOADED  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid_i,
  input  logic [31:0]           load_data_i,
  input  logic                  load_last_i,
  output logic                  load_ready_o,
  output logic                  loaded_o,
  input  logic [ADDR_WIDTH-1:0] inst_addr_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [31:0]           inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_valid_o,
  output logic                  fetch_err_o
);

  localparam int unsigned            IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]       PTR_LAST = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]       PTR_ONE  = IDX_W'(1);
  localparam logic [ADDR_WIDTH-1:0]  DEPTH_W  = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0]  SENTINEL = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [31:0]      mem [DEPTH];
  logic             load_hs;
  logic             addr_sentinel;
  logic             addr_bad;
  logic [IDX_W-1:0] rd_idx;

  always_comb begin
    state_nxt    = state;
    load_ready_o = 1'b0;
    loaded_o     = 1'b0;
    case (state)
      S_LOAD: begin
        load_ready_o = 1'b1;
        if (load_valid_i && (load_last_i || ptr == PTR_LAST))
          state_nxt = S_RUN;
      end
      S_RUN: loaded_o = 1'b1;
      default: state_nxt = S_LOAD;
    endcase
  end

  assign load_hs = load_valid_i & load_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (PRELOADED != 0) ? S_RUN : S_LOAD;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (load_hs)
        ptr <= ptr + PTR_ONE;
    end
  end

  // Array has no reset; writes are blocked while rst is asserted.
  always_ff @(posedge clk) begin
    if (!rst && load_hs)
      mem[ptr] <= load_data_i;
  end

  // Range check uses the whole word field so high address bits cannot alias.
  assign addr_sentinel = (inst_addr_i == SENTINEL);
  assign addr_bad      = (inst_addr_i[1:0] != 2'b00) ||
                         ({2'b00, inst_addr_i[ADDR_WIDTH-1:2]} >= DEPTH_W);
  assign rd_idx        = inst_addr_i[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_o       <= NOP;
      inst_pc_o    <= '0;
      inst_valid_o <= 1'b0;
      fetch_err_o  <= 1'b0;
    end else if (state == S_RUN) begin
      if (flush_i) begin
        inst_o       <= NOP;
        inst_valid_o <= 1'b0;
      end else if (stall_i) begin
        inst_o       <= inst_o;
      end else if (addr_sentinel) begin
        inst_o       <= NOP;
        inst_valid_o <= 1'b0;
      end else if (addr_bad) begin
        inst_o       <= NOP;
        inst_valid_o <= 1'b0;
        fetch_err_o  <= 1'b1;
      end else begin
        inst_o       <= mem[rd_idx];
        inst_pc_o    <= inst_addr_i;
        inst_valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Directed bench for inst_mem_fetch: spec-level model feeds a scoreboard queue
// that is popped and checked one cycle after each fetch.
module tb_inst_mem_fetch;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready, loaded;
  logic [31:0] inst_addr = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, fetch_err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        err;
    logic        pc_chk;
  } exp_t;

  exp_t sb[$];

  logic [31:0] tb_mem [DEPTH];
  logic [31:0] m_inst, m_pc;
  logic        m_valid, m_err, m_run;
  int          m_ptr;

  inst_mem_fetch #(.ADDR_WIDTH(32), .DEPTH(DEPTH), .NOP(NOP), .PRELOADED(0)) dut (
    .clk(clk), .rst(rst),
    .load_valid_i(load_valid), .load_data_i(load_data), .load_last_i(load_last),
    .load_ready_o(load_ready), .loaded_o(loaded),
    .inst_addr_i(inst_addr), .stall_i(stall), .flush_i(flush),
    .inst_o(inst), .inst_pc_o(inst_pc), .inst_valid_o(inst_valid),
    .fetch_err_o(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_inst = NOP; m_pc = '0; m_valid = 1'b0; m_err = 1'b0; m_run = 1'b0; m_ptr = 0;
    chk("rst_inst", inst, NOP);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_err", {31'h0, fetch_err}, 32'h0);
    chk("rst_ready", {31'h0, load_ready}, 32'h1);
    chk("rst_loaded", {31'h0, loaded}, 32'h0);
  endtask

  // One boot word; verbose=1 checks the handshake signals around it.
  task automatic load_word(input logic [31:0] data, input logic last, input bit verbose);
    @(negedge clk);
    load_valid = 1'b1; load_data = data; load_last = last;
    if (verbose) chk("ld_ready_pre", {31'h0, load_ready}, {31'h0, ~m_run});
    if (!m_run) begin
      tb_mem[m_ptr] = data;
      if (last || m_ptr == DEPTH - 1) m_run = 1'b1;
      m_ptr++;
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0; load_last = 1'b0;
    if (verbose) begin
      chk("ld_loaded", {31'h0, loaded}, {31'h0, m_run});
      chk("ld_ready_post", {31'h0, load_ready}, {31'h0, ~m_run});
    end
  endtask

  task automatic step(input string tag, input logic [31:0] addr, input logic st, input logic fl);
    exp_t e;
    @(negedge clk);
    inst_addr = addr; stall = st; flush = fl;
    e.pc_chk = 1'b1;
    if (m_run) begin
      if (fl) begin
        m_inst = NOP; m_valid = 1'b0;
      end else if (st) begin
        m_inst = m_inst;
      end else if (addr == 32'hFFFF_FFFC) begin
        m_inst = NOP; m_valid = 1'b0; e.pc_chk = 1'b0;
      end else if (addr[1:0] != 2'b00 || addr[31:2] >= DEPTH) begin
        m_inst = NOP; m_valid = 1'b0; m_err = 1'b1; e.pc_chk = 1'b0;
      end else begin
        m_inst = tb_mem[addr[11:2]]; m_pc = addr; m_valid = 1'b1;
      end
    end
    e.inst = m_inst; e.pc = m_pc; e.valid = m_valid; e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_inst"}, inst, e.inst);
    if (e.pc_chk) chk({tag, "_pc"}, inst_pc, e.pc);
    chk({tag, "_valid"}, {31'h0, inst_valid}, {31'h0, e.valid});
    chk({tag, "_err"}, {31'h0, fetch_err}, {31'h0, e.err});
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    m_inst = NOP; m_pc = '0; m_valid = 1'b0; m_err = 1'b0; m_run = 1'b0; m_ptr = 0;

    // Auto-terminate: fill every word without ever raising last.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      load_word(32'hC000_0000 | i, 1'b0, 1'b0);
      if (i == DEPTH - 2) chk("auto_not_yet", {31'h0, loaded}, 32'h0);
    end
    chk("auto_loaded", {31'h0, loaded}, 32'h1);
    chk("auto_ready", {31'h0, load_ready}, 32'h0);
    step("auto_last", 32'h0000_0FFC, 1'b0, 1'b0);
    chk("auto_last_const", inst, 32'hC000_03FF);
    step("auto_first", 32'h0, 1'b0, 1'b0);

    // Four-word load ending with last; fetches during LOAD stay parked.
    do_reset();
    step("load_park", 32'h0, 1'b0, 1'b0);
    load_word(32'h1111_1111, 1'b0, 1'b1);
    load_word(32'h2222_2222, 1'b0, 1'b1);
    load_word(32'h3333_3333, 1'b0, 1'b1);
    chk("ld3_loaded", {31'h0, loaded}, 32'h0);
    load_word(32'h4444_4444, 1'b1, 1'b1);
    chk("ld4_loaded", {31'h0, loaded}, 32'h1);
    load_word(32'h5555_5555, 1'b1, 1'b1);

    step("seq0", 32'h0, 1'b0, 1'b0);
    chk("seq0_const", inst, 32'h1111_1111);
    step("seq4", 32'h4, 1'b0, 1'b0);
    step("seq8", 32'h8, 1'b0, 1'b0);
    chk("seq8_const", inst, 32'h3333_3333);
    step("stall1", 32'hC, 1'b1, 1'b0);
    step("stall2", 32'hC, 1'b1, 1'b0);
    chk("stall_pc_const", inst_pc, 32'h8);
    step("flush_stall", 32'hC, 1'b1, 1'b1);
    chk("flush_pc_const", inst_pc, 32'h8);
    step("sentinel", 32'hFFFF_FFFC, 1'b0, 1'b0);
    step("word4_kept", 32'h10, 1'b0, 1'b0);
    chk("word4_const", inst, 32'hC000_0004);
    step("misalign", 32'h6, 1'b0, 1'b0);
    chk("misalign_err_const", {31'h0, fetch_err}, 32'h1);
    step("after_err0", 32'h0, 1'b0, 1'b0);
    step("after_err12", 32'hC, 1'b0, 1'b0);
    step("stall_no_err", 32'h2, 1'b1, 1'b0);

    // Range errors, including a high address that would alias if truncated.
    do_reset();
    load_word(32'h0123_4567, 1'b1, 1'b1);
    step("oor_1000", 32'h0000_1000, 1'b0, 1'b0);
    do_reset();
    load_word(32'h0123_4567, 1'b1, 1'b1);
    step("oor_high", 32'h4000_0000, 1'b0, 1'b0);
    step("oor_high_ok", 32'h0, 1'b0, 1'b0);

    // Reset in the middle of a load restarts the pointer.
    do_reset();
    load_word(32'hBBBB_0000, 1'b0, 1'b1);
    load_word(32'hBBBB_0001, 1'b0, 1'b1);
    do_reset();
    load_word(32'hAAAA_AAAA, 1'b1, 1'b1);
    step("reld_w0", 32'h0, 1'b0, 1'b0);
    chk("reld_w0_const", inst, 32'hAAAA_AAAA);
    step("reld_w1", 32'h4, 1'b0, 1'b0);
    chk("reld_w1_const", inst, 32'hBBBB_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
